// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC core control path:
// one-hot state encoding for the sequencer and opcodes shared with the decoder.
package cpu_pkg;

  localparam int NUM_STATES = 7;

  localparam int FETCH_BIT     = 0;
  localparam int DECODE_BIT    = 1;
  localparam int REGREAD_BIT   = 2;
  localparam int EXECUTE_BIT   = 3;
  localparam int MEMORY_BIT    = 4;
  localparam int WRITEBACK_BIT = 5;
  localparam int HALT_BIT      = 6;

  typedef enum logic [NUM_STATES-1:0] {
    ST_FETCH     = 7'b0000001,
    ST_DECODE    = 7'b0000010,
    ST_REGREAD   = 7'b0000100,
    ST_EXECUTE   = 7'b0001000,
    ST_MEMORY    = 7'b0010000,
    ST_WRITEBACK = 7'b0100000,
    ST_HALT      = 7'b1000000
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Counts cycles spent waiting on memory; expired flags that the wait has reached LIMIT.
module wait_timer #(
  parameter int TMR_W = 8,
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMR_W-1:0] count;

  // Clear has priority so a completed request never leaves a stale count behind.
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TMR_W'(LIMIT));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 16-bit RISC core: steps each instruction
// through fetch, decode, register read, execute, optional memory and writeback.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stall,
  input  logic                  i_is_mem,
  input  logic                  i_wb_en,
  input  logic                  i_is_halt,
  input  logic                  i_mem_ready,
  output logic [NUM_STATES-1:0] o_state,
  output logic                  o_fetch_en,
  output logic                  o_dec_en,
  output logic                  o_reg_en,
  output logic                  o_reg_we,
  output logic                  o_alu_en,
  output logic                  o_mem_req,
  output logic                  o_pc_en,
  output logic                  o_halted,
  output logic                  o_fault
);

  state_t stateQ;
  state_t nextState;
  logic   wbFlagQ;
  logic   memFlagQ;
  logic   faultQ;
  logic   captureFlags;
  logic   setFault;
  logic   strobeGate;
  logic   waiting;
  logic   readyNow;
  logic   timerClear;
  logic   timerEnable;
  logic   timerExpired;

  assign strobeGate  = !i_stall && !i_rst;
  assign waiting     = stateQ[FETCH_BIT] || stateQ[MEMORY_BIT];
  assign readyNow    = waiting && !i_stall && i_mem_ready;
  // Holding the timer at zero outside the wait states gives the clear-on-entry behaviour.
  assign timerClear  = i_rst || !waiting || readyNow;
  assign timerEnable = waiting && !i_stall;

  wait_timer #(
    .TMR_W (TMR_W),
    .LIMIT (MEM_TIMEOUT)
  ) uWaitTimer (
    .clock   (i_clk),
    .clear   (timerClear),
    .enable  (timerEnable),
    .expired (timerExpired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stateQ   <= ST_FETCH;
      wbFlagQ  <= 1'b0;
      memFlagQ <= 1'b0;
      faultQ   <= 1'b0;
    end else begin
      stateQ <= nextState;
      if (captureFlags) begin
        wbFlagQ  <= i_wb_en;
        memFlagQ <= i_is_mem;
      end
      if (setFault) begin
        faultQ <= 1'b1;
      end
    end
  end

  // A stall freezes everything; a ready that arrives on the expiry cycle still completes.
  always_comb begin
    nextState    = stateQ;
    captureFlags = 1'b0;
    setFault     = 1'b0;
    if (!i_stall) begin
      case (stateQ)
        ST_FETCH, ST_MEMORY: begin
          if (i_mem_ready) begin
            nextState = stateQ[FETCH_BIT] ? ST_DECODE : ST_WRITEBACK;
          end else if (timerExpired) begin
            nextState = ST_HALT;
            setFault  = 1'b1;
          end
        end
        ST_DECODE: begin
          captureFlags = 1'b1;
          nextState    = i_is_halt ? ST_HALT : ST_REGREAD;
        end
        ST_REGREAD:   nextState = ST_EXECUTE;
        ST_EXECUTE:   nextState = memFlagQ ? ST_MEMORY : ST_WRITEBACK;
        ST_WRITEBACK: nextState = ST_FETCH;
        ST_HALT:      nextState = ST_HALT;
        default:      nextState = ST_FETCH;
      endcase
    end
  end

  assign o_state    = stateQ;
  assign o_fetch_en = strobeGate && stateQ[FETCH_BIT] && i_mem_ready;
  assign o_dec_en   = strobeGate && stateQ[DECODE_BIT];
  assign o_reg_en   = strobeGate && (stateQ[REGREAD_BIT] || stateQ[WRITEBACK_BIT]);
  assign o_reg_we   = strobeGate && stateQ[WRITEBACK_BIT] && wbFlagQ;
  assign o_alu_en   = strobeGate && stateQ[EXECUTE_BIT];
  assign o_mem_req  = strobeGate && waiting;
  assign o_pc_en    = strobeGate && stateQ[WRITEBACK_BIT];
  assign o_halted   = stateQ[HALT_BIT];
  assign o_fault    = faultQ;

endmodule
